// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles every bus signal around the memory-port arbiter: the IFU and LSU
//   request/response ports, the forwarded memory port and the two status bits.
//   Signal names are the core's own (ifu_*, lsu_*, mem_*).
//
//   modport slave  : the arbiter's view (takes requests, drives memory side)
//   modport master : the environment's view (IFU, LSU and memory model)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
  // IFU port
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  // LSU port
  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic [1:0]  lsu_size;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  // memory port
  logic        mem_reqValid;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [1:0]  mem_size;
  logic        mem_respValid;
  logic [31:0] mem_rdata;
  // status
  logic        busy;
  logic        timeout_err;

  modport slave (
    input  ifu_reqValid, ifu_addr,
    output ifu_respValid, ifu_rdata,
    input  lsu_reqValid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_size,
    output lsu_respValid, lsu_rdata,
    output mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_size,
    input  mem_respValid, mem_rdata,
    output busy, timeout_err
  );

  modport master (
    output ifu_reqValid, ifu_addr,
    input  ifu_respValid, ifu_rdata,
    output lsu_reqValid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_size,
    input  lsu_respValid, lsu_rdata,
    input  mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_size,
    output mem_respValid, mem_rdata,
    input  busy, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between the IFU and the LSU, one outstanding
//   transaction at a time. LSU has priority, but after MAX_LSU_STREAK
//   consecutive LSU wins against a waiting IFU the IFU is forced through.
//   A memory that never answers is cut off after TIMEOUT_CYCLES wait cycles
//   and the requester receives 32'hdeadbeef plus a timeout_err pulse.
//
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : mem_port_arbiter_if.slave (IFU, LSU, memory ports, busy, timeout_err)
//
//   Flow: IDLE (arbitrate, latch) -> REQ (mem_reqValid pulse) -> WAIT
//         (response or timeout) -> RESP (requester respValid pulse) -> IDLE.
//   Every output comes from a flop.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int MAX_LSU_STREAK = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus
);

  localparam int SW = $clog2(MAX_LSU_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]   ERR_DATA   = 32'hdeadbeef;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_grant_lsu;
  logic [SW-1:0] r_streak;
  logic [TW-1:0] r_tcnt;
  logic [31:0]   r_cap;

  logic          r_mem_req, r_mem_wen;
  logic [31:0]   r_mem_addr, r_mem_wdata;
  logic [3:0]    r_mem_wmask;
  logic [1:0]    r_mem_size;
  logic          r_ifu_resp, r_lsu_resp;
  logic [31:0]   r_ifu_rdata, r_lsu_rdata;
  logic          r_busy, r_terr;

  logic          w_req_any, w_pick_lsu, w_timeout, w_done;
  logic [31:0]   w_cap_nxt;

  assign w_req_any  = bus.ifu_reqValid | bus.lsu_reqValid;
  // LSU wins unless the IFU is waiting and the streak budget is spent.
  assign w_pick_lsu = bus.lsu_reqValid & (~bus.ifu_reqValid | (r_streak != STREAK_MAX));
  // A real response in the last allowed cycle beats the timeout.
  assign w_timeout  = (r_tcnt == TO_LAST) & ~bus.mem_respValid;
  assign w_done     = bus.mem_respValid | w_timeout;
  assign w_cap_nxt  = bus.mem_respValid ? bus.mem_rdata : ERR_DATA;

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req_any) w_state_nxt = S_REQ;
      S_REQ:   w_state_nxt = S_WAIT;
      S_WAIT:  if (w_done) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // datapath and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_grant_lsu <= 1'b0;
      r_streak    <= '0;
      r_tcnt      <= '0;
      r_cap       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wen   <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
      r_mem_size  <= '0;
      r_ifu_resp  <= 1'b0;
      r_ifu_rdata <= '0;
      r_lsu_resp  <= 1'b0;
      r_lsu_rdata <= '0;
      r_busy      <= 1'b0;
      r_terr      <= 1'b0;
    end else begin
      r_mem_req  <= 1'b0;
      r_ifu_resp <= 1'b0;
      r_lsu_resp <= 1'b0;
      r_terr     <= 1'b0;
      r_busy     <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: if (w_req_any) begin
          r_mem_req   <= 1'b1;
          r_grant_lsu <= w_pick_lsu;
          if (w_pick_lsu) begin
            r_mem_addr  <= bus.lsu_addr;
            r_mem_wen   <= bus.lsu_wen;
            r_mem_wdata <= bus.lsu_wdata;
            r_mem_wmask <= bus.lsu_wmask;
            r_mem_size  <= bus.lsu_size;
            // only wins taken over a waiting IFU count toward the streak
            if (bus.ifu_reqValid)
              r_streak <= (r_streak == STREAK_MAX) ? r_streak : r_streak + 1'b1;
            else
              r_streak <= '0;
          end else begin
            r_mem_addr  <= bus.ifu_addr;
            r_mem_wen   <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_wmask <= 4'b0000;
            r_mem_size  <= 2'b10;
            r_streak    <= '0;
          end
        end
        S_REQ: r_tcnt <= '0;
        S_WAIT: begin
          if (w_done) begin
            r_cap  <= w_cap_nxt;
            r_terr <= w_timeout;
            // rdata is loaded alongside the capture so it is valid in RESP
            if (r_grant_lsu) begin
              r_lsu_resp  <= 1'b1;
              r_lsu_rdata <= w_cap_nxt;
            end else begin
              r_ifu_resp  <= 1'b1;
              r_ifu_rdata <= w_cap_nxt;
            end
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_reqValid  = r_mem_req;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wen       = r_mem_wen;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.mem_wmask     = r_mem_wmask;
  assign bus.mem_size      = r_mem_size;
  assign bus.ifu_respValid = r_ifu_resp;
  assign bus.ifu_rdata     = r_ifu_rdata;
  assign bus.lsu_respValid = r_lsu_resp;
  assign bus.lsu_rdata     = r_lsu_rdata;
  assign bus.busy          = r_busy;
  assign bus.timeout_err   = r_terr;

endmodule
